// File: rtl/mux5_rr_arbiter_pkg.sv
// Shared constants and helpers for the 5-requester round-robin arbiter.
package mux5_rr_arbiter_pkg;

  localparam int N_REQ = 5;
  localparam int SRC_W = 3;

  // One-hot legs of mux5_module; an all-zero select falls through to din4.
  localparam logic [3:0] SEL_D0 = 4'b0001;
  localparam logic [3:0] SEL_D1 = 4'b0010;
  localparam logic [3:0] SEL_D2 = 4'b0100;
  localparam logic [3:0] SEL_D3 = 4'b1000;
  localparam logic [3:0] SEL_D4 = 4'b0000;

  function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] idx);
    return (idx >= SRC_W'(N_REQ - 1)) ? '0 : idx + SRC_W'(1);
  endfunction

  function automatic logic [3:0] sel_of(input logic [SRC_W-1:0] idx);
    logic [3:0] s;
    case (idx)
      3'd0:    s = SEL_D0;
      3'd1:    s = SEL_D1;
      3'd2:    s = SEL_D2;
      3'd3:    s = SEL_D3;
      default: s = SEL_D4;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mux5_module.sv
// 5:1 data mux with one-hot select; any select that is not a single known leg picks din4.
module mux5_module #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] din1,
  input  logic [DATA_WIDTH-1:0] din2,
  input  logic [DATA_WIDTH-1:0] din3,
  input  logic [DATA_WIDTH-1:0] din4,
  input  logic [3:0]            sel,
  output logic [DATA_WIDTH-1:0] dout
);

  always_comb begin
    case (sel)
      4'b0001: dout = din0;
      4'b0010: dout = din1;
      4'b0100: dout = din2;
      4'b1000: dout = din3;
      default: dout = din4;
    endcase
  end

endmodule

// File: rtl/mux5_rr_arbiter.sv
// Round-robin arbiter in front of a shared 5:1 mux, with a single registered output stage
// and optional per-requester burst stickiness.
module mux5_rr_arbiter
  import mux5_rr_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        arb_en,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [SRC_W-1:0]            out_src
);

  localparam int BW = $clog2(MAX_BURST + 1);

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic [SRC_W-1:0]      out_src_q,   out_src_d;
  logic [SRC_W-1:0]      cur_q,       cur_d;
  logic [BW-1:0]         burst_q,     burst_d;

  logic                  load;
  logic                  stick;
  logic                  found;
  logic [SRC_W-1:0]      cand;
  logic [SRC_W-1:0]      winner;
  logic [3:0]            mux_sel;
  logic [DATA_WIDTH-1:0] mux_out;

  assign load  = arb_en && (|req_valid) && (!out_valid_q || out_ready);
  assign stick = (MAX_BURST > 1) && req_valid[cur_q] && (burst_q < BW'(MAX_BURST - 1));

  // Scan starts just past the last winner and reaches cur itself last.
  always_comb begin
    winner = cur_q;
    found  = 1'b0;
    cand   = cur_q;
    if (stick) begin
      found = 1'b1;
    end
    for (int k = 0; k < N_REQ; k++) begin
      cand = wrap_inc(cand);
      if (!found && req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (load) req_ready[winner] = 1'b1;
  end

  assign mux_sel = sel_of(winner);

  mux5_module #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mux (
    .din0 (req_data[0*DATA_WIDTH +: DATA_WIDTH]),
    .din1 (req_data[1*DATA_WIDTH +: DATA_WIDTH]),
    .din2 (req_data[2*DATA_WIDTH +: DATA_WIDTH]),
    .din3 (req_data[3*DATA_WIDTH +: DATA_WIDTH]),
    .din4 (req_data[4*DATA_WIDTH +: DATA_WIDTH]),
    .sel  (mux_sel),
    .dout (mux_out)
  );

  // Draining and loading on the same edge replaces the word with no bubble.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    cur_d       = cur_q;
    burst_d     = burst_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_out;
      out_src_d   = winner;
      cur_d       = winner;
      burst_d     = stick ? burst_q + BW'(1) : '0;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      cur_q       <= SRC_W'(N_REQ - 1);
      burst_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      cur_q       <= cur_d;
      burst_q     <= burst_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux5_rr_arbiter.sv
// Two arbiters (MAX_BURST=1 and 2) on shared stimulus, each checked against its own
// rule-level reference model.
module tb_mux5_rr_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         arb_en;
  logic         out_ready;
  logic [4:0]   req_valid;
  logic [159:0] req_data;

  logic         ov [2];
  logic [31:0]  od [2];
  logic [2:0]   os [2];
  logic [4:0]   rr [2];

  always #5 clk = ~clk;

  mux5_rr_arbiter #(.DATA_WIDTH(32), .MAX_BURST(1)) u_a (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req_valid(req_valid), .req_ready(rr[0]),
    .req_data(req_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .out_src(os[0]));

  mux5_rr_arbiter #(.DATA_WIDTH(32), .MAX_BURST(2)) u_b (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req_valid(req_valid), .req_ready(rr[1]),
    .req_data(req_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .out_src(os[1]));

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference state: last winner, beats granted back-to-back, and the output word.
  int          mb    [2] = '{1, 2};
  int          m_cur [2];
  int          m_bc  [2];
  bit          m_ov  [2];
  logic [31:0] m_od  [2];
  int          m_os  [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cur[d] = 4; m_bc[d] = 0; m_ov[d] = 0; m_od[d] = '0; m_os[d] = 0;
    end
  endtask

  // One clock: check every output at the falling edge, advance the model, step to posedge+1.
  task automatic cycle();
    bit         ld, st, hit;
    int         w, c;
    logic [4:0] rdy;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      ld  = arb_en && (req_valid != 0) && (!m_ov[d] || out_ready);
      st  = (mb[d] > 1) && req_valid[m_cur[d]] && (m_bc[d] < mb[d] - 1);
      w   = m_cur[d];
      hit = st;
      for (int k = 1; k <= 5; k++) begin
        c = (m_cur[d] + k) % 5;
        if (!hit && req_valid[c]) begin w = c; hit = 1; end
      end
      rdy = ld ? 5'(1 << w) : 5'd0;
      chk($sformatf("d%0d out_valid", d), 64'(ov[d]), 64'(m_ov[d]));
      chk($sformatf("d%0d out_data", d), 64'(od[d]), 64'(m_od[d]));
      chk($sformatf("d%0d out_src", d), 64'(os[d]), 64'(m_os[d]));
      chk($sformatf("d%0d req_ready", d), 64'(rr[d]), 64'(rdy));
      if (ld) begin
        m_bc[d]  = st ? m_bc[d] + 1 : 0;
        m_ov[d]  = 1;
        m_od[d]  = req_data[w*32 +: 32];
        m_os[d]  = w;
        m_cur[d] = w;
      end else if (m_ov[d] && out_ready) begin
        m_ov[d] = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Reset asserted between edges: outputs must clear without waiting for a clock.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d rst out_valid", d), 64'(ov[d]), 64'd0);
      chk($sformatf("d%0d rst out_data", d), 64'(od[d]), 64'd0);
      chk($sformatf("d%0d rst out_src", d), 64'(os[d]), 64'd0);
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_data_tagged();
    for (int i = 0; i < 5; i++) req_data[i*32 +: 32] = 32'hA5A5_0000 | 32'(i);
  endtask

  int seq2 [10] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 0};

  initial begin
    rst_n = 1'b1; arb_en = 1'b0; out_ready = 1'b0; req_valid = '0; req_data = '0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Pure round robin across all requesters.
    set_data_tagged();
    req_valid = 5'h1F; out_ready = 1'b1; arb_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("s1 src", 64'(os[0]), 64'(k % 5));
      chk("s1 data", 64'(od[0]), 64'(32'hA5A5_0000 | 32'(k % 5)));
    end

    // Mid-transfer reset, then burst of two per requester.
    do_reset();
    req_valid = 5'h01;
    cycle();
    chk("s2 first", 64'(os[1]), 64'd0);
    req_valid = 5'h1F;
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("s2 seq", 64'(os[1]), 64'(seq2[k]));
    end
    cycle();
    chk("s2 stick0", 64'(os[1]), 64'd0);
    cycle();
    chk("s2 to1", 64'(os[1]), 64'd1);
    req_valid = 5'b11101;
    cycle();
    chk("s2 drop1", 64'(os[1]), 64'd2);

    // Backpressure for three cycles, then release.
    req_valid = 5'h1F; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("s3 ready", 64'(rr[0]), 64'd0);
    end
    out_ready = 1'b1;
    cycle();
    cycle();

    // Single requesters through the default and top one-hot legs.
    req_valid = 5'h10;
    cycle();
    chk("s4 data4", 64'(od[0]), 64'h0000_0000_A5A5_0004);
    chk("s4 src4", 64'(os[0]), 64'd4);
    req_valid = 5'h08;
    cycle();
    chk("s4 src3", 64'(os[0]), 64'd3);
    chk("s4 data3", 64'(od[0]), 64'h0000_0000_A5A5_0003);

    // Disable with a word still held: it drains and nothing new is granted.
    req_valid = 5'h1F; arb_en = 1'b0;
    cycle();
    chk("s6 drained", 64'(ov[0]), 64'd0);
    chk("s6 ready", 64'(rr[0]), 64'd0);
    cycle();
    arb_en = 1'b1;
    cycle();

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 500; n++) begin
      req_valid = 5'($urandom);
      for (int i = 0; i < 5; i++) req_data[i*32 +: 32] = $urandom;
      out_ready = ($urandom % 4) != 0;
      arb_en    = ($urandom % 8) != 0;
      if ($urandom % 60 == 0) do_reset();
      else cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
